sb_cfg_tile: RTL and testbench

Parametrised corner switch-block tile with a built-in configuration chain. It generalises the fixed-width corner tile: channel width and pad-pin count are parameters, and each output track has a 4-way routing mode instead of a fixed hard-wired pattern. Configuration is double-buffered: bits shift into a shadow chain and take effect only on an explicit commit, so routing never glitches while the chain loads. An optional loop-back mode recirculates the chain for non-destructive readback. The block sits at fabric corners, on the same `ccff_head`/`ccff_tail` chain as the other tiles.

---
 rtl/sb_cfg_tile.sv | 110 +++++++++++
 tb/tb_sb_cfg_tile.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_cfg_tile.sv
// Corner switch-block tile with a double-buffered configuration chain:
// bits shift into a shadow register and only reach the routing muxes on commit.
module sb_cfg_tile #(
    parameter int CHAN_W = 65,
    parameter int N_PIN  = 4
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic [0:CHAN_W-1] chanx_right_in,
    input  logic [0:CHAN_W-1] chany_bottom_in,
    input  logic [0:N_PIN-1]  pin_in,
    output logic [0:CHAN_W-1] chanx_right_out,
    output logic [0:CHAN_W-1] chany_bottom_out,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              ccff_loop,
    input  logic              cfg_commit,
    output logic              ccff_tail,
    output logic              cfg_loaded,
    output logic              cfg_valid,
    output logic              cfg_err
);

    localparam int CFG_LEN = 4 * CHAN_W;
    localparam int CNT_W   = $clog2(CFG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);

    typedef enum logic [1:0] {
        MODE_STRAIGHT = 2'd0,
        MODE_TWIST    = 2'd1,
        MODE_PIN      = 2'd2,
        MODE_OFF      = 2'd3
    } route_mode_e;

    logic [0:CFG_LEN-1] sh;
    logic [0:CFG_LEN-1] act;
    logic [CNT_W-1:0]   cnt;

    assign cfg_loaded = (cnt == CNT_FULL);
    assign ccff_tail  = sh[CFG_LEN-1];

    // NOTE: the configuration registers are reset explicitly (not left to
    // power-up), so a mid-load reset leaves a known all-zero shadow and active set.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            sh        <= '0;
            act       <= '0;
            cnt       <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (ccff_en) begin
                // NOTE: non-blocking assignments let every stage read the old
                // neighbour value, which is what makes this a shift register.
                sh <= {(ccff_loop ? sh[CFG_LEN-1] : ccff_head), sh[0:CFG_LEN-2]};
                if (!cfg_loaded) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (cfg_commit) begin
                    cfg_err <= 1'b1;
                end
            end else if (cfg_commit) begin
                if (cfg_loaded) begin
                    act       <= sh;
                    cfg_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < CHAN_W; i++) begin : g_route
        route_mode_e sel_x;
        route_mode_e sel_y;
        logic        mux_x;
        logic        mux_y;

        assign sel_x = route_mode_e'({act[2*i], act[2*i+1]});
        assign sel_y = route_mode_e'({act[2*CHAN_W+2*i], act[2*CHAN_W+2*i+1]});

        // NOTE: each mux output gets a default before the case so no latch
        // can be inferred if a mode is ever left uncovered.
        always_comb begin
            mux_x = 1'b0;
            case (sel_x)
                MODE_STRAIGHT: mux_x = chany_bottom_in[i];
                MODE_TWIST:    mux_x = chany_bottom_in[(i+1) % CHAN_W];
                MODE_PIN:      mux_x = pin_in[i % N_PIN];
                default:       mux_x = 1'b0;
            endcase
        end

        always_comb begin
            mux_y = 1'b0;
            case (sel_y)
                MODE_STRAIGHT: mux_y = chanx_right_in[i];
                MODE_TWIST:    mux_y = chanx_right_in[(i+1) % CHAN_W];
                MODE_PIN:      mux_y = pin_in[i % N_PIN];
                default:       mux_y = 1'b0;
            endcase
        end

        assign chanx_right_out[i]  = mux_x & cfg_valid;
        assign chany_bottom_out[i] = mux_y & cfg_valid;
    end

endmodule

// File: tb/tb_sb_cfg_tile.sv
// Scoreboard bench for sb_cfg_tile: a queue-based chain model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_sb_cfg_tile;

    localparam int CW = 4;
    localparam int NP = 2;
    localparam int CL = 4 * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:CW-1] chanx_in, chany_in, chanx_out, chany_out;
    logic [0:NP-1] pin;
    logic          ccff_head, ccff_en, ccff_loop, cfg_commit;
    logic          tail, loaded, valid, err;

    always #5 clk = ~clk;

    sb_cfg_tile #(.CHAN_W(CW), .N_PIN(NP)) dut (
        .prog_clk         (clk),
        .prog_reset_n     (rst_n),
        .chanx_right_in   (chanx_in),
        .chany_bottom_in  (chany_in),
        .pin_in           (pin),
        .chanx_right_out  (chanx_out),
        .chany_bottom_out (chany_out),
        .ccff_head        (ccff_head),
        .ccff_en          (ccff_en),
        .ccff_loop        (ccff_loop),
        .cfg_commit       (cfg_commit),
        .ccff_tail        (tail),
        .cfg_loaded       (loaded),
        .cfg_valid        (valid),
        .cfg_err          (err)
    );

    typedef struct {
        logic [0:CW-1] xo;
        logic [0:CW-1] yo;
        logic          tail;
        logic          loaded;
        logic          valid;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: shadow chain as a queue (front = head end), active
    // configuration as a flat array, shift count as a plain integer.
    bit m_sh[$];
    bit m_act[CL];
    int m_cnt;
    bit m_valid, m_err;
    bit m_known = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit route(input int mode, input logic [0:CW-1] src,
                                 input logic [0:NP-1] p, input int i);
        case (mode)
            0:       return src[i];
            1:       return src[(i + 1) % CW];
            2:       return p[i % NP];
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t predict();
        exp_t e;
        for (int i = 0; i < CW; i++) begin
            int mx = 2 * int'(m_act[2*i]) + int'(m_act[2*i+1]);
            int my = 2 * int'(m_act[2*CW+2*i]) + int'(m_act[2*CW+2*i+1]);
            e.xo[i] = m_valid & route(mx, chany_in, pin, i);
            e.yo[i] = m_valid & route(my, chanx_in, pin, i);
        end
        e.tail   = m_sh[CL-1];
        e.loaded = (m_cnt == CL);
        e.valid  = m_valid;
        e.err    = m_err;
        return e;
    endfunction

    task automatic model_step(input bit en, input bit head, input bit loop,
                              input bit commit, input bit rst);
        bit nb;
        if (rst) begin
            m_sh.delete();
            for (int k = 0; k < CL; k++) m_sh.push_back(1'b0);
            foreach (m_act[k]) m_act[k] = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            m_err = 1'b0;
            if (en) begin
                nb = loop ? m_sh[CL-1] : head;
                m_sh.push_front(nb);
                void'(m_sh.pop_back());
                if (m_cnt < CL) m_cnt++;
                if (commit) m_err = 1'b1;
            end else if (commit) begin
                if (m_cnt == CL) begin
                    for (int k = 0; k < CL; k++) m_act[k] = m_sh[k];
                    m_valid = 1'b1;
                    m_cnt   = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // One clock cycle: apply controls, record the expected outputs for this
    // cycle, advance the model, then move to just after the next rising edge.
    task automatic cyc(input bit en, input bit head, input bit loop,
                       input bit commit, input bit rst = 1'b0);
        ccff_en    = en;
        ccff_head  = head;
        ccff_loop  = loop;
        cfg_commit = commit;
        rst_n      = !rst;
        if (m_known) sb_q.push_back(predict());
        model_step(en, head, loop, commit, rst);
        @(posedge clk);
        #1;
    endtask

    // The first bit shifted lands at the far end, so feed cfg[CL-1] first.
    task automatic load(input logic [0:CL-1] cfg);
        for (int k = CL - 1; k >= 0; k--) cyc(1'b1, cfg[k], 1'b0, 1'b0);
    endtask

    task automatic rand_inputs();
        chanx_in = CW'($urandom);
        chany_in = CW'($urandom);
        pin      = NP'($urandom);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("chanx_right_out",  32'(chanx_out), 32'(e.xo));
                check("chany_bottom_out", 32'(chany_out), 32'(e.yo));
                check("ccff_tail",        32'(tail),      32'(e.tail));
                check("cfg_loaded",       32'(loaded),    32'(e.loaded));
                check("cfg_valid",        32'(valid),     32'(e.valid));
                check("cfg_err",          32'(err),       32'(e.err));
            end
        end
    end

    initial begin : stimulus
        logic [0:CL-1] pat;
        rst_n      = 1'b0;
        ccff_en    = 1'b0;
        ccff_head  = 1'b0;
        ccff_loop  = 1'b0;
        cfg_commit = 1'b0;
        chanx_in   = '0;
        chany_in   = '0;
        pin        = '0;
        @(posedge clk);
        #1;

        // Reset held while every input toggles.
        for (int k = 0; k < 4; k++) begin
            rand_inputs();
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        rand_inputs();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_tail",  32'(tail),  32'd0);
        check("reset_xout",  32'(chanx_out), 32'd0);
        check("reset_yout",  32'(chany_out), 32'd0);

        // Straight route.
        load('0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chany_in = 4'b1010;
        chanx_in = 4'b0110;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("straight_valid", 32'(valid), 32'd1);
        check("straight_xout",  32'(chanx_out), 32'(4'b1010));
        check("straight_yout",  32'(chany_out), 32'(4'b0110));

        // Twist / pin / off: selx = {0,1,2,3}, sely all off.
        load(16'b0001_1011_1111_1111);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chany_in = 4'b0100;
        pin      = 2'b11;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            rand_inputs();
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Premature commit after 15 shifts, then the 16th shift.
        for (int k = 0; k < CL - 1; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Shadow isolation while a new pattern streams through.
        pat = CL'($urandom);
        for (int k = CL - 1; k >= 0; k--) begin
            rand_inputs();
            cyc(1'b1, pat[k], 1'b0, 1'b0);
        end
        rand_inputs();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Readback loop, re-commit, then a commit colliding with a shift.
        for (int k = 0; k < CL; k++) begin
            rand_inputs();
            cyc(1'b1, 1'($urandom), 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        rand_inputs();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a load.
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic with runs of shifting and occasional commits.
        for (int k = 0; k < 600; k++) begin
            rand_inputs();
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 249) == 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
